// File: rtl/cvxif_mac_pkg.sv
// ---------------------------------------------------------------------------
// cvxif_mac_pkg
// Shared definitions for the CV-X-IF multiply-accumulate coprocessor:
//   - custom-3 opcode / funct7 / funct3 encodings
//   - FSM state enum and decoded operation enum
//   - issue_latch_t, the per-transaction record captured at issue
//   - decode helpers used by the top-level issue logic
// ---------------------------------------------------------------------------
package cvxif_mac_pkg;

    // Default datapath and transaction-ID widths. The top-level parameters
    // default to these and the issue latch is sized from them.
    localparam int unsigned MacXlen    = 32;
    localparam int unsigned MacIdWidth = 2;

    localparam logic [6:0] OPCODE_CUSTOM3 = 7'b1111011;
    localparam logic [6:0] FUNCT7_MAC     = 7'b0000000;

    localparam logic [2:0] FUNCT3_MACC   = 3'b000;
    localparam logic [2:0] FUNCT3_ACCRD  = 3'b001;
    localparam logic [2:0] FUNCT3_ACCCLR = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_RESULT = 2'd2
    } mac_state_e;

    typedef enum logic [1:0] {
        OP_MACC   = 2'd0,
        OP_ACCRD  = 2'd1,
        OP_ACCCLR = 2'd2
    } mac_op_e;

    typedef struct packed {
        logic [MacIdWidth-1:0] id;
        logic [4:0]            rd;
        mac_op_e               op;
        logic [MacXlen-1:0]    rs1;
        logic [MacXlen-1:0]    rs2;
    } issue_latch_t;

    // True when the instruction word belongs to this coprocessor's
    // custom-3 space (opcode and funct7 both match).
    function automatic logic is_mac_space(input logic [31:0] instr);
        return (instr[6:0] == OPCODE_CUSTOM3) && (instr[31:25] == FUNCT7_MAC);
    endfunction

    // Maps funct3 to an operation; unknown encodings fall back to ACCRD,
    // but the accept logic rejects them so the value is never used.
    function automatic mac_op_e decode_op(input logic [2:0] funct3);
        case (funct3)
            FUNCT3_MACC:   return OP_MACC;
            FUNCT3_ACCCLR: return OP_ACCCLR;
            default:       return OP_ACCRD;
        endcase
    endfunction

endpackage

// File: rtl/cvxif_mac_mul_iter.sv
// ---------------------------------------------------------------------------
// cvxif_mac_mul_iter
// Iterative XLEN x XLEN -> XLEN (truncated) shift-add multiplier that
// consumes 8 bits of the multiplier operand per cycle over 4 cycles.
//
// Ports:
//   i_clk      clock
//   i_rst_n    asynchronous active-low reset
//   i_start    load operands and restart the 4-step sequence
//   i_a        multiplier operand (consumed a byte at a time, LSB first)
//   i_b        multiplicand operand
//   o_done     high in the final step cycle and held until the next start
//   o_product  truncated product; valid whenever o_done is high
// ---------------------------------------------------------------------------
module cvxif_mac_mul_iter
    import cvxif_mac_pkg::*;
#(
    parameter int unsigned XLEN = MacXlen
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_product
);

    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_prod;
    logic [1:0]      r_count;
    logic            r_active;
    logic            r_done;

    logic [XLEN-1:0] w_step;
    logic [XLEN-1:0] w_partial;
    logic            w_lastStep;

    // One partial product per cycle: the low byte of the shifted multiplier
    // times the already-aligned multiplicand, accumulated modulo 2^XLEN.
    assign w_step     = r_b * XLEN'(r_a[7:0]);
    assign w_partial  = r_prod + w_step;
    assign w_lastStep = r_active && (r_count == 2'd3);

    // Done is raised combinationally in the last step so the caller can
    // act on the complete product in the same cycle it is formed.
    assign o_done    = r_done || w_lastStep;
    assign o_product = r_done ? r_prod : w_partial;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_prod   <= '0;
            r_count  <= 2'd0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_start) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_prod   <= '0;
            r_count  <= 2'd0;
            r_active <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_active) begin
            r_a     <= r_a >> 8;
            r_b     <= r_b << 8;
            r_prod  <= w_partial;
            r_count <= r_count + 2'd1;
            if (w_lastStep) begin
                r_active <= 1'b0;
                r_done   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cvxif_mac_coprocessor.sv
// ---------------------------------------------------------------------------
// cvxif_mac_coprocessor
// Single-entry CV-X-IF responder implementing custom-3 MACC / ACCRD / ACCCLR
// against an internal accumulator. Work is speculative until the matching
// commit arrives; a matching kill discards it without touching the
// accumulator.
//
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   issue_valid_i / issue_ready_o      issue handshake
//   issue_instr_i, issue_id_i          instruction word and transaction ID
//   issue_rs_i, issue_rs_valid_i       {rs2, rs1} operands and their valids
//   issue_accept_o, issue_writeback_o  combinational decode response
//   commit_valid_i, commit_id_i,
//   commit_kill_i                      commit / kill strobe
//   result_valid_o / result_ready_i    result handshake
//   result_id_o, result_data_o,
//   result_rd_o, result_we_o           registered result payload
// ---------------------------------------------------------------------------
module cvxif_mac_coprocessor
    import cvxif_mac_pkg::*;
#(
    parameter int unsigned XLEN    = MacXlen,
    parameter int unsigned IdWidth = MacIdWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 issue_valid_i,
    output logic                 issue_ready_o,
    input  logic [31:0]          issue_instr_i,
    input  logic [IdWidth-1:0]   issue_id_i,
    input  logic [2*XLEN-1:0]    issue_rs_i,
    input  logic [1:0]           issue_rs_valid_i,
    output logic                 issue_accept_o,
    output logic                 issue_writeback_o,
    input  logic                 commit_valid_i,
    input  logic [IdWidth-1:0]   commit_id_i,
    input  logic                 commit_kill_i,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic [IdWidth-1:0]   result_id_o,
    output logic [XLEN-1:0]      result_data_o,
    output logic [4:0]           result_rd_o,
    output logic                 result_we_o
);

    mac_state_e       r_state;
    logic             r_issueReady;
    issue_latch_t     r_latch;
    logic             r_committed;
    logic [XLEN-1:0]  r_acc;
    logic             r_resultValid;
    logic [IdWidth-1:0] r_resultId;
    logic [XLEN-1:0]  r_resultData;
    logic [4:0]       r_resultRd;
    logic             r_resultWe;

    mac_state_e       w_nextState;
    mac_op_e          w_op;
    logic             w_accept;
    logic             w_issueFire;
    logic             w_commitIssue;
    logic             w_commitBusy;
    logic             w_done;
    logic             w_mulStart;
    logic             w_mulDone;
    logic [XLEN-1:0]  w_product;
    logic             w_loadLatch;
    logic             w_enterResult;
    logic [XLEN-1:0]  w_resultData;
    logic             w_unusedBits;

    // The register-index fields of the instruction are not needed (operands
    // arrive on issue_rs_i), and the latched operands are kept only as a
    // record of the transaction; the multiplier holds its own working copy.
    assign w_unusedBits = ^{issue_instr_i[24:15], r_latch.rs1, r_latch.rs2};

    // Decode is purely combinational on the instruction and operand valids
    // so the core sees accept/writeback in the handshake cycle.
    always_comb begin
        w_accept = 1'b0;
        w_op     = decode_op(issue_instr_i[14:12]);
        if (is_mac_space(issue_instr_i)) begin
            case (issue_instr_i[14:12])
                FUNCT3_MACC:   w_accept = &issue_rs_valid_i;
                FUNCT3_ACCRD:  w_accept = 1'b1;
                FUNCT3_ACCCLR: w_accept = 1'b1;
                default:       w_accept = 1'b0;
            endcase
        end
    end

    assign issue_accept_o    = w_accept;
    assign issue_writeback_o = w_accept;

    assign w_issueFire   = issue_valid_i && r_issueReady && w_accept;
    assign w_commitIssue = commit_valid_i && (commit_id_i == issue_id_i);
    assign w_commitBusy  = commit_valid_i && (commit_id_i == r_latch.id);
    assign w_done        = (r_latch.op == OP_MACC) ? w_mulDone : 1'b1;

    cvxif_mac_mul_iter #(
        .XLEN (XLEN)
    ) u_mul (
        .i_clk     (clk_i),
        .i_rst_n   (rst_ni),
        .i_start   (w_mulStart),
        .i_a       (issue_rs_i[XLEN-1:0]),
        .i_b       (issue_rs_i[2*XLEN-1:XLEN]),
        .o_done    (w_mulDone),
        .o_product (w_product)
    );

    // Value written to rd (and, for MACC/ACCCLR, to the accumulator) when
    // the transaction retires into RESULT.
    always_comb begin
        w_resultData = r_acc;
        case (r_latch.op)
            OP_MACC:   w_resultData = r_acc + w_product;
            OP_ACCCLR: w_resultData = '0;
            default:   w_resultData = r_acc;
        endcase
    end

    // Next-state logic. A commit arriving in the same cycle that the work
    // finishes counts immediately, which is what lets a cycle-4 commit still
    // produce a cycle-5 MACC result. A matching kill wins over completion.
    always_comb begin
        w_nextState   = r_state;
        w_loadLatch   = 1'b0;
        w_mulStart    = 1'b0;
        w_enterResult = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_issueFire && !(w_commitIssue && commit_kill_i)) begin
                    w_loadLatch = 1'b1;
                    w_mulStart  = (w_op == OP_MACC);
                    w_nextState = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_commitBusy && commit_kill_i) begin
                    w_nextState = ST_IDLE;
                end else if (w_done && (r_committed || w_commitBusy)) begin
                    w_enterResult = 1'b1;
                    w_nextState   = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (result_ready_i) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State register plus a registered copy of "next state is IDLE" so that
    // issue_ready_o comes straight from a flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_issueReady <= 1'b1;
        end else begin
            r_state      <= w_nextState;
            r_issueReady <= (w_nextState == ST_IDLE);
        end
    end

    // Transaction record and commit tracking. A non-kill commit may already
    // be present in the issue cycle, so it is sampled together with the latch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_latch     <= '0;
            r_committed <= 1'b0;
        end else if (w_loadLatch) begin
            r_latch     <= '{id:  issue_id_i,
                             rd:  issue_instr_i[11:7],
                             op:  w_op,
                             rs1: issue_rs_i[XLEN-1:0],
                             rs2: issue_rs_i[2*XLEN-1:XLEN]};
            r_committed <= w_commitIssue && !commit_kill_i;
        end else if (w_enterResult) begin
            r_committed <= 1'b0;
        end else if ((r_state == ST_BUSY) && w_commitBusy && !commit_kill_i) begin
            r_committed <= 1'b1;
        end
    end

    // Accumulator only changes on retirement, so killed work never leaks in.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc <= '0;
        end else if (w_enterResult && (r_latch.op != OP_ACCRD)) begin
            r_acc <= w_resultData;
        end
    end

    // Result channel registers: loaded on entry to RESULT and held stable
    // until the core takes the result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_resultValid <= 1'b0;
            r_resultId    <= '0;
            r_resultData  <= '0;
            r_resultRd    <= '0;
            r_resultWe    <= 1'b0;
        end else if (w_enterResult) begin
            r_resultValid <= 1'b1;
            r_resultId    <= r_latch.id;
            r_resultData  <= w_resultData;
            r_resultRd    <= r_latch.rd;
            r_resultWe    <= 1'b1;
        end else if ((r_state == ST_RESULT) && result_ready_i) begin
            r_resultValid <= 1'b0;
            r_resultWe    <= 1'b0;
        end
    end

    assign issue_ready_o  = r_issueReady;
    assign result_valid_o = r_resultValid;
    assign result_id_o    = r_resultId;
    assign result_data_o  = r_resultData;
    assign result_rd_o    = r_resultRd;
    assign result_we_o    = r_resultWe;

endmodule
